// File: rtl/regfile_sb.sv
// regfile_sb -- parametrised multi-read-port register file with a busy-bit
// scoreboard and a post-reset clearing sequencer.
//
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read
// forwarding on every read port). Undefined by default.
//
// Ports:
//   clk       clock, all state updates on posedge
//   rst       synchronous active-high reset (restarts the clear sequence)
//   ra        NRD packed read addresses, port i at [i*AW +: AW]
//   rd        NRD packed read data, port i at [i*XLEN +: XLEN]
//   rd_busy   per-port pending flag (register has an outstanding producer)
//   we/wa/wd  writeback write port
//   iss_en    issue strobe, marks iss_wa as pending
//   iss_wa    destination register of the issuing instruction
//   ready     high once the clear sequence is complete
//   dbg_regs  flattened architectural state, entry 0 always zero
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*XLEN-1:0]   rd,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_wa,
  output logic                  ready,
  output logic [NREGS*XLEN-1:0] dbg_regs
);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rf [NREGS];
  logic [NREGS-1:0] busy;

  logic wr_ok;
  logic iss_ok;

  assign wr_ok  = (state_q == READY) && we && (wa != '0);
  assign iss_ok = (state_q == READY) && iss_en && (iss_wa != '0);

  // Sequencer state register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST) state_d = READY;
      end
      READY: ready = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  // Storage. The sequencer zeroes one entry per cycle after reset.
  // NOTE: the array has no reset branch on purpose; clearing goes through the
  // single write port so it maps onto plain RAM/flops without a wide reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        rf[cnt_q] <= '0;
      end else if (wr_ok) begin
        rf[wa] <= wd;
      end
    end
  end

  // Scoreboard. Issue is applied after writeback so a new producer to the
  // same register in the same cycle leaves the bit set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        busy[cnt_q] <= 1'b0;
      end else begin
        if (wr_ok)  busy[wa]     <= 1'b0;
        if (iss_ok) busy[iss_wa] <= 1'b1;
      end
    end
  end

  // Read ports: zero during CLEAR and for register 0.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] data;
    logic            pend;

    assign a = ra[p*AW +: AW];

    always_comb begin
      data = '0;
      pend = 1'b0;
      if (state_q == READY && a != '0) begin
        data = rf[a];
        pend = busy[a];
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight writeback; a same-cycle issue only shows
        // up as busy from the next cycle.
        if (we && wa == a) begin
          data = wd;
          pend = 1'b0;
        end
`endif
      end
    end

    assign rd[p*XLEN +: XLEN] = data;
    assign rd_busy[p]         = pend;
  end

  // Debug view mirrors storage directly, no forwarding.
  for (genvar r = 0; r < NREGS; r++) begin : g_dbg
    if (r == 0) begin : g_zero
      assign dbg_regs[0 +: XLEN] = '0;
    end else begin : g_reg
      assign dbg_regs[r*XLEN +: XLEN] = rf[r];
    end
  end

endmodule
